// File: rtl/pn2112_pkg.sv
// Shared constants, tap positions and state type for the PN-2112 descrambler slice.
// Latency: none (definitions only).
// Backpressure: none (definitions only).
package pn2112_pkg;

  localparam int PN_WORD_W = 32;
  localparam int PN_WORDS  = 66;
  localparam int PN_LFSR_W = 58;
  localparam int PN_IDX_W  = 7;

  // Polynomial 1 + x^39 + x^58
  localparam int PN_TAP_A = 39;
  localparam int PN_TAP_B = 58;

  localparam logic [PN_LFSR_W-1:0] PN_SEED     = {PN_LFSR_W{1'b1}};
  localparam logic [PN_IDX_W-1:0]  PN_LAST_IDX = 7'(PN_WORDS - 1);

  typedef enum logic {
    HUNT = 1'b0,
    RUN  = 1'b1
  } pn_state_t;

endpackage

// File: rtl/pn2112_lfsr32.sv
// Combinational 32-step advance of the PN-2112 Fibonacci LFSR, plus the 32 sequence bits it emits.
// Latency: purely combinational; the caller owns the state register.
// Backpressure: none; the caller decides when to take next_state.
module pn2112_lfsr32
  import pn2112_pkg::*;
(
  input  logic [PN_LFSR_W-1:0] state,
  output logic [PN_WORD_W-1:0] pn,
  output logic [PN_LFSR_W-1:0] next_state
);

  // state[i] holds sequence bit s[n+i]; the oldest bit leaves first, and the
  // new bit is s[n+58] = s[n+19] ^ s[n] (taps at x^39 and x^58).
  localparam int FB_IDX = PN_TAP_B - PN_TAP_A;

  logic [PN_LFSR_W-1:0] work;

  // Unrolled 32 single-bit steps; bit 0 of pn is the earliest sequence bit
  always_comb begin
    work = state;
    pn   = '0;
    for (int i = 0; i < PN_WORD_W; i++) begin
      pn[i] = work[0];
      work  = {work[FB_IDX] ^ work[0], work[PN_LFSR_W-1:1]};
    end
    next_state = work;
  end

endmodule

// File: rtl/pn2112_descrambler.sv
// Receive PN-2112 descrambler: XORs each 32-bit word of a 66-word FEC block with the on-the-fly PN sequence.
// Latency: 1 cycle, all outputs registered; one word per cycle.
// Backpressure: none; words arrive on din_valid and are never stalled. Optional framing check: PN2112_SOB_CHECK_EN.
module pn2112_descrambler
  import pn2112_pkg::*;
(
  input  logic                 clk,
  input  logic                 arst_n,
  input  logic                 din_valid,
  input  logic                 din_sob,
  input  logic [PN_WORD_W-1:0] din,
  output logic                 dout_valid,
  output logic                 dout_sob,
  output logic [PN_WORD_W-1:0] dout,
  output logic [PN_IDX_W-1:0]  dout_idx,
  output logic                 block_err
);

  pn_state_t             state_q, state_d;
  logic [PN_LFSR_W-1:0]  lfsr_q, lfsr_d, lfsr_in, lfsr_step;
  logic [PN_IDX_W-1:0]   idx_q, idx_d, emit_idx;
  logic [PN_WORD_W-1:0]  pn_word;
  logic                  accept;
  logic                  reseed;
  logic                  drop_to_hunt;
  logic                  err_d;

  logic                  dout_valid_q, dout_sob_q, block_err_q;
  logic [PN_WORD_W-1:0]  dout_q;
  logic [PN_IDX_W-1:0]   dout_idx_q;

  // A word taken as word 0 always starts from the seed, whatever the register holds
  assign lfsr_in = reseed ? PN_SEED : lfsr_q;

  pn2112_lfsr32 u_lfsr (
    .state      (lfsr_in),
    .pn         (pn_word),
    .next_state (lfsr_step)
  );

  // State, LFSR and word-index registers
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q <= HUNT;
      lfsr_q  <= PN_SEED;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      idx_q   <= idx_d;
    end
  end

  // Framing decode: decide whether this word is accepted, restarts a block, or is dropped
  always_comb begin
    state_d      = state_q;
    accept       = 1'b0;
    reseed       = 1'b0;
    drop_to_hunt = 1'b0;
    err_d        = 1'b0;
    if (din_valid) begin
      case (state_q)
        HUNT: begin
          if (din_sob) begin
            accept  = 1'b1;
            reseed  = 1'b1;
            state_d = RUN;
          end
        end
        RUN: begin
          if (din_sob) begin
            // sob always realigns; off-boundary sob is a framing slip
            accept = 1'b1;
            reseed = 1'b1;
`ifdef PN2112_SOB_CHECK_EN
            err_d  = (idx_q != '0);
`endif
          end else if (idx_q == '0) begin
`ifdef PN2112_SOB_CHECK_EN
            // Expected a new block but no sob: lose lock
            err_d        = 1'b1;
            drop_to_hunt = 1'b1;
            state_d      = HUNT;
`else
            // Free-run: the LFSR was already reloaded on the wrap
            accept = 1'b1;
`endif
          end else begin
            accept = 1'b1;
          end
        end
        default: state_d = HUNT;
      endcase
    end
  end

  // Next index and LFSR: wrap after word 65 and reload the seed for the next block
  always_comb begin
    emit_idx = reseed ? '0 : idx_q;
    idx_d    = idx_q;
    lfsr_d   = lfsr_q;
    if (accept) begin
      if (emit_idx == PN_LAST_IDX) begin
        idx_d  = '0;
        lfsr_d = PN_SEED;
      end else begin
        idx_d  = emit_idx + 7'd1;
        lfsr_d = lfsr_step;
      end
    end else if (drop_to_hunt) begin
      idx_d  = '0;
      lfsr_d = PN_SEED;
    end
  end

  // Output registers; data and index hold when no word is emitted
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      dout_valid_q <= 1'b0;
      dout_sob_q   <= 1'b0;
      dout_q       <= '0;
      dout_idx_q   <= '0;
      block_err_q  <= 1'b0;
    end else begin
      dout_valid_q <= accept;
      dout_sob_q   <= accept && (emit_idx == '0);
      block_err_q  <= err_d;
      if (accept) begin
        dout_q     <= din ^ pn_word;
        dout_idx_q <= emit_idx;
      end
    end
  end

  assign dout_valid = dout_valid_q;
  assign dout_sob   = dout_sob_q;
  assign dout       = dout_q;
  assign dout_idx   = dout_idx_q;
  assign block_err  = block_err_q;

endmodule

// File: tb/tb_pn2112_descrambler.sv
// Directed bench for pn2112_descrambler with an independent bit-serial PN-2112 model.
// Inputs change on the falling edge; outputs are checked on the following falling edge.
// Expectations follow PN2112_SOB_CHECK_EN when it is defined for the build.
module tb_pn2112_descrambler;

  logic        clk = 1'b0;
  logic        arst_n;
  logic        din_valid;
  logic        din_sob;
  logic [31:0] din;
  logic        dout_valid;
  logic        dout_sob;
  logic [31:0] dout;
  logic [6:0]  dout_idx;
  logic        block_err;

  int checks = 0;
  int errors = 0;

  logic pn_bits [0:2111];

  pn2112_descrambler dut (
    .clk        (clk),
    .arst_n     (arst_n),
    .din_valid  (din_valid),
    .din_sob    (din_sob),
    .din        (din),
    .dout_valid (dout_valid),
    .dout_sob   (dout_sob),
    .dout       (dout),
    .dout_idx   (dout_idx),
    .block_err  (block_err)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] pnw(input int k);
    logic [31:0] w;
    for (int j = 0; j < 32; j++) w[j] = pn_bits[32*k + j];
    return w;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic v, input logic s, input logic [31:0] d);
    din_valid = v;
    din_sob   = s;
    din       = d;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_word(input string tag, input int k, input logic [31:0] exp);
    chk({tag, "_valid"}, 32'(dout_valid), 32'd1);
    chk({tag, "_idx"},   32'(dout_idx),   32'(k));
    chk({tag, "_sob"},   32'(dout_sob),   32'(k == 0));
    chk({tag, "_dat"},   dout,            exp);
  endtask

  initial begin
    logic [31:0] p;

    // Reference sequence: seed of 58 ones, then s[n] = s[n-39] ^ s[n-58]
    for (int n = 0; n < 2112; n++)
      pn_bits[n] = (n < 58) ? 1'b1 : (pn_bits[n-39] ^ pn_bits[n-58]);

    arst_n = 1'b0; din_valid = 1'b0; din_sob = 1'b0; din = '0;
    #2;
    chk("rst_valid", 32'(dout_valid), 32'd0);
    chk("rst_sob",   32'(dout_sob),   32'd0);
    chk("rst_dout",  dout,            32'd0);
    chk("rst_idx",   32'(dout_idx),   32'd0);
    chk("rst_err",   32'(block_err),  32'd0);
    @(negedge clk); @(negedge clk);
    arst_n = 1'b1;
    @(negedge clk);

    // Zero-input block: output is the raw PN sequence
    for (int k = 0; k < 66; k++) begin
      step(1'b1, k == 0, 32'h0);
      check_word("zero", k, pnw(k));
      if (k == 0) chk("zero_w0_const", dout, 32'hffffffff);
      if (k == 1) chk("zero_w1_const", dout, 32'h03ffffff);
    end
    step(1'b0, 1'b0, 32'h0);
    chk("zero_idle_valid", 32'(dout_valid), 32'd0);

    // Round trip: three back-to-back blocks
    for (int b = 0; b < 3; b++) begin
      for (int k = 0; k < 66; k++) begin
        p = $urandom;
        step(1'b1, k == 0, p ^ pnw(k));
        check_word("rt", k, p);
        chk("rt_err", 32'(block_err), 32'd0);
      end
    end

    // Hunt discard: reset into HUNT, ten words without sob are dropped
    arst_n = 1'b0;
    @(negedge clk);
    arst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 1'b0, $urandom);
      chk("hunt_valid", 32'(dout_valid), 32'd0);
    end
    for (int k = 0; k < 66; k++) begin
      p = $urandom;
      step(1'b1, k == 0, p ^ pnw(k));
      check_word("hunt_blk", k, p);
    end

    // Misplaced sob at word 20
    for (int k = 0; k < 20; k++) begin
      p = $urandom;
      step(1'b1, k == 0, p ^ pnw(k));
      chk("mis_pre_dat", dout, p);
    end
    p = $urandom;
    step(1'b1, 1'b1, p ^ pnw(0));
    check_word("mis_sob", 0, p);
`ifdef PN2112_SOB_CHECK_EN
    chk("mis_err", 32'(block_err), 32'd1);
`else
    chk("mis_err", 32'(block_err), 32'd0);
`endif
    for (int k = 1; k < 66; k++) begin
      p = $urandom;
      step(1'b1, 1'b0, p ^ pnw(k));
      check_word("mis_post", k, p);
      if (k == 1) chk("mis_err_pulse", 32'(block_err), 32'd0);
    end

    // Missing sob where word 0 is expected
    p = $urandom;
    step(1'b1, 1'b0, p ^ pnw(0));
`ifdef PN2112_SOB_CHECK_EN
    chk("miss_err",   32'(block_err),  32'd1);
    chk("miss_valid", 32'(dout_valid), 32'd0);
    step(1'b1, 1'b0, $urandom);
    chk("miss_hunt_valid", 32'(dout_valid), 32'd0);
    chk("miss_hunt_err",   32'(block_err),  32'd0);
`else
    check_word("miss_wrap", 0, p);
    chk("miss_err", 32'(block_err), 32'd0);
`endif

    // Stall at word 30, then reset at word 40
    for (int k = 0; k < 30; k++) begin
      p = $urandom;
      step(1'b1, k == 0, p ^ pnw(k));
      check_word("stall_pre", k, p);
    end
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b0, $urandom);
      chk("stall_valid", 32'(dout_valid), 32'd0);
    end
    for (int k = 30; k < 41; k++) begin
      p = $urandom;
      step(1'b1, 1'b0, p ^ pnw(k));
      check_word("stall_post", k, p);
    end
    #2;
    arst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(dout_valid), 32'd0);
    chk("arst_sob",   32'(dout_sob),   32'd0);
    chk("arst_dout",  dout,            32'd0);
    chk("arst_idx",   32'(dout_idx),   32'd0);
    chk("arst_err",   32'(block_err),  32'd0);
    @(negedge clk);
    arst_n = 1'b1;
    for (int k = 0; k < 66; k++) begin
      p = $urandom;
      step(1'b1, k == 0, p ^ pnw(k));
      check_word("post_rst", k, p);
      chk("post_rst_err", 32'(block_err), 32'd0);
    end
    step(1'b0, 1'b0, 32'h0);
    chk("end_idle_valid", 32'(dout_valid), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
